// File: rtl/fu_completion_scheduler_pkg.sv
// Shared widths, unit-state encodings and helpers for the EX-stage
// completion scheduler.
package fu_completion_scheduler_pkg;

    localparam int NUM_FUNC_UNITS    = 5;
    localparam int FUNC_UNIT_OP_SIZE = 3;
    localparam int LAT_SIZE          = 4;
    localparam int ROB_ID_SIZE       = 4;

    typedef logic [1:0] fu_state_t;

    localparam fu_state_t FU_IDLE = 2'd0;
    localparam fu_state_t FU_EXEC = 2'd1;
    localparam fu_state_t FU_DONE = 2'd2;

    // A latency of zero from the control unit means "single cycle".
    function automatic logic [LAT_SIZE-1:0] eff_latency(input logic [LAT_SIZE-1:0] lat);
        return (lat == '0) ? LAT_SIZE'(1) : lat;
    endfunction

endpackage

// File: rtl/fu_completion_scheduler_if.sv
// Issue / completion / scoreboard bundle between ID, the scheduler and WB.
interface fu_completion_scheduler_if;
    import fu_completion_scheduler_pkg::*;

    logic                         issue_valid;
    logic [FUNC_UNIT_OP_SIZE-1:0] issue_unit;
    logic [LAT_SIZE-1:0]          issue_latency;
    logic [ROB_ID_SIZE-1:0]       issue_id;
    logic                         wb_ready;
    logic [NUM_FUNC_UNITS-1:0]    free_units;
    logic                         done_valid;
    logic [FUNC_UNIT_OP_SIZE-1:0] done_unit;
    logic [ROB_ID_SIZE-1:0]       done_id;
    logic                         issue_error;

    modport master (
        output issue_valid, issue_unit, issue_latency, issue_id, wb_ready,
        input  free_units, done_valid, done_unit, done_id, issue_error
    );

    modport slave (
        input  issue_valid, issue_unit, issue_latency, issue_id, wb_ready,
        output free_units, done_valid, done_unit, done_id, issue_error
    );

endinterface

// File: rtl/fu_completion_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr_i,
// wrapping modulo N. The pointer register belongs to the caller.
module rr_arbiter #(
    parameter  int N  = 5,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan N positions starting at the pointer and take the first request.
    always_comb begin
        int   c;
        logic found;
        c     = 0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        any_o = |req_i;
        for (int i = 0; i < N; i++) begin
            c = (int'(ptr_i) + i) % N;
            if (!found && req_i[c]) begin
                found    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/fu_completion_scheduler.sv
// EX-stage occupancy tracker and completion scheduler. Marks units busy on
// issue, counts their latency down, and hands finished units one at a time
// to the WB/ROB completion port.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  FU_IDLE | unit free, may accept an issue
//  FU_EXEC | executing, cnt_q = cycles left before the result is offered
//  FU_DONE | result ready, waiting for a WB grant (unit still busy)
module fu_completion_scheduler
    import fu_completion_scheduler_pkg::*;
#(
    parameter int NUM_UNITS = NUM_FUNC_UNITS
) (
    input  logic                      clk,
    input  logic                      reset,
    fu_completion_scheduler_if.slave  sched
);

    localparam int PW  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int PAD = 2 ** FUNC_UNIT_OP_SIZE;

    logic [NUM_UNITS-1:0]                  is_idle;
    logic [NUM_UNITS-1:0]                  is_done;
    logic [NUM_UNITS-1:0][ROB_ID_SIZE-1:0] id_vec;
    logic [NUM_UNITS-1:0]                  arb_oh;
    logic [NUM_UNITS-1:0]                  win_oh;
    logic [NUM_UNITS-1:0]                  grant_oh;
    logic [PW-1:0]                         arb_idx;
    logic [PW-1:0]                         win_idx;
    logic                                  any_done;
    logic                                  grant;
    logic [PAD-1:0]                        free_pad;
    logic                                  issue_legal;
    logic [LAT_SIZE-1:0]                   lat_eff;

    logic [PW-1:0] rr_q, rr_d;
    logic          lock_vld_q, lock_vld_d;
    logic [PW-1:0] lock_idx_q, lock_idx_d;
    logic          issue_error_q, issue_error_d;

    // Out-of-range unit indices land on the zero padding and are never free.
    assign free_pad    = PAD'(is_idle);
    assign issue_legal = sched.issue_valid & free_pad[sched.issue_unit];
    assign lat_eff     = eff_latency(sched.issue_latency);

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        fu_state_t              state_q, state_d;
        logic [LAT_SIZE-1:0]    cnt_q, cnt_d;
        logic [ROB_ID_SIZE-1:0] id_q, id_d;
        logic                   hit;

        assign hit = issue_legal & (sched.issue_unit == FUNC_UNIT_OP_SIZE'(u));

        // Per-unit next state; a single-cycle op is offered the cycle after issue.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            id_d    = id_q;
            case (state_q)
                FU_IDLE: begin
                    if (hit) begin
                        id_d = sched.issue_id;
                        if (lat_eff == LAT_SIZE'(1)) begin
                            state_d = FU_DONE;
                            cnt_d   = '0;
                        end else begin
                            state_d = FU_EXEC;
                            cnt_d   = lat_eff - LAT_SIZE'(1);
                        end
                    end
                end
                FU_EXEC: begin
                    cnt_d = cnt_q - LAT_SIZE'(1);
                    if (cnt_q == LAT_SIZE'(1)) begin
                        state_d = FU_DONE;
                    end
                end
                FU_DONE: begin
                    if (grant_oh[u]) begin
                        state_d = FU_IDLE;
                    end
                end
                default: begin
                    state_d = FU_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Per-unit state, down-counter and ROB id registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= FU_IDLE;
                cnt_q   <= '0;
                id_q    <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                id_q    <= id_d;
            end
        end

        assign is_idle[u] = (state_q == FU_IDLE);
        assign is_done[u] = (state_q == FU_DONE);
        assign id_vec[u]  = id_q;
    end

    rr_arbiter #(.N(NUM_UNITS)) u_arb (
        .req_i (is_done),
        .ptr_i (rr_q),
        .gnt_o (arb_oh),
        .idx_o (arb_idx),
        .any_o (any_done)
    );

    // A stalled offer is pinned so a newly finished unit cannot displace it.
    assign win_idx  = lock_vld_q ? lock_idx_q : arb_idx;
    assign win_oh   = lock_vld_q ? (NUM_UNITS'(1) << lock_idx_q) : arb_oh;
    assign grant    = any_done & sched.wb_ready;
    assign grant_oh = grant ? win_oh : '0;

    // Offer mux: winner's id when something is done, zero otherwise.
    always_comb begin
        sched.done_id = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (any_done && win_oh[u]) begin
                sched.done_id = id_vec[u];
            end
        end
    end

    assign sched.free_units  = is_idle;
    assign sched.done_valid  = any_done;
    assign sched.done_unit   = any_done ? FUNC_UNIT_OP_SIZE'(win_idx) : '0;
    assign sched.issue_error = issue_error_q;

    // Pointer advance past the winner on grant; offer lock while WB stalls.
    always_comb begin
        rr_d          = rr_q;
        lock_vld_d    = lock_vld_q;
        lock_idx_d    = lock_idx_q;
        issue_error_d = sched.issue_valid & ~issue_legal;
        if (grant) begin
            rr_d       = (win_idx == PW'(NUM_UNITS - 1)) ? '0 : win_idx + PW'(1);
            lock_vld_d = 1'b0;
        end else if (any_done) begin
            lock_vld_d = 1'b1;
            lock_idx_d = win_idx;
        end
    end

    // Arbitration pointer, offer lock and issue-error pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q          <= '0;
            lock_vld_q    <= 1'b0;
            lock_idx_q    <= '0;
            issue_error_q <= 1'b0;
        end else begin
            rr_q          <= rr_d;
            lock_vld_q    <= lock_vld_d;
            lock_idx_q    <= lock_idx_d;
            issue_error_q <= issue_error_d;
        end
    end

endmodule

// File: tb/tb_fu_completion_scheduler.sv
// Directed bench for fu_completion_scheduler: a per-cycle vector table plus
// hand-written sequences for simultaneous finish, back-pressure and reset.
module tb_fu_completion_scheduler;
    import fu_completion_scheduler_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fu_completion_scheduler_if bus();

    fu_completion_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .sched (bus)
    );

    typedef struct {
        logic       iv;
        logic [2:0] iu;
        logic [3:0] il;
        logic [3:0] iid;
        logic       wb;
        logic [4:0] free;
        logic       dv;
        logic [2:0] du;
        logic [3:0] did;
        logic       err;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic iv, logic [2:0] iu, logic [3:0] il, logic [3:0] iid,
                                logic wb, logic [4:0] free, logic dv, logic [2:0] du,
                                logic [3:0] did, logic err);
        vec_t v;
        v.iv = iv; v.iu = iu; v.il = il; v.iid = iid; v.wb = wb;
        v.free = free; v.dv = dv; v.du = du; v.did = did; v.err = err;
        return v;
    endfunction

    // One cycle: check this cycle's outputs at the falling edge, then drive
    // this cycle's inputs (sampled at the next rising edge).
    task automatic cyc(input string tag, input logic iv, input logic [2:0] iu,
                       input logic [3:0] il, input logic [3:0] iid, input logic wb,
                       input logic [4:0] ef, input logic edv, input logic [2:0] edu,
                       input logic [3:0] edid, input logic eerr, input logic rst = 1'b0);
        @(negedge clk);
        total++;
        if ({bus.free_units, bus.done_valid, bus.done_unit, bus.done_id, bus.issue_error}
            !== {ef, edv, edu, edid, eerr}) begin
            bad++;
            $display("FAIL %s: got free=%b dv=%b unit=%0d id=%0d err=%b, want free=%b dv=%b unit=%0d id=%0d err=%b",
                     tag, bus.free_units, bus.done_valid, bus.done_unit, bus.done_id,
                     bus.issue_error, ef, edv, edu, edid, eerr);
        end
        bus.issue_valid   = iv;
        bus.issue_unit    = iu;
        bus.issue_latency = il;
        bus.issue_id      = iid;
        bus.wb_ready      = wb;
        reset             = rst;
    endtask

    initial begin
        //            iv iu il  iid wb  free      dv du did err
        vecs[0]  = mk(1, 2, 3,  7,  1, 5'b11111, 0, 0, 0,  0); // reset state; issue u2 L3
        vecs[1]  = mk(0, 0, 0,  0,  1, 5'b11011, 0, 0, 0,  0);
        vecs[2]  = mk(0, 0, 0,  0,  1, 5'b11011, 0, 0, 0,  0);
        vecs[3]  = mk(0, 0, 0,  0,  1, 5'b11011, 1, 2, 7,  0); // offered at t+3
        vecs[4]  = mk(0, 0, 0,  0,  1, 5'b11111, 0, 0, 0,  0); // free at t+4
        vecs[5]  = mk(1, 1, 0,  5,  1, 5'b11111, 0, 0, 0,  0); // latency 0 on u1
        vecs[6]  = mk(0, 0, 0,  0,  1, 5'b11101, 1, 1, 5,  0);
        vecs[7]  = mk(0, 0, 0,  0,  1, 5'b11111, 0, 0, 0,  0);
        vecs[8]  = mk(1, 5, 2,  3,  1, 5'b11111, 0, 0, 0,  0); // unit 5 out of range
        vecs[9]  = mk(0, 0, 0,  0,  1, 5'b11111, 0, 0, 0,  1);
        vecs[10] = mk(1, 0, 4,  1,  1, 5'b11111, 0, 0, 0,  0); // u0 L4
        vecs[11] = mk(1, 0, 1,  2,  1, 5'b11110, 0, 0, 0,  0); // issue to busy u0
        vecs[12] = mk(0, 0, 0,  0,  1, 5'b11110, 0, 0, 0,  1);
        vecs[13] = mk(0, 0, 0,  0,  1, 5'b11110, 0, 0, 0,  0);
        vecs[14] = mk(0, 0, 0,  0,  1, 5'b11110, 1, 0, 1,  0); // original id kept
        vecs[15] = mk(1, 3, 2,  9,  1, 5'b11111, 0, 0, 0,  0);
        vecs[16] = mk(1, 4, 1, 10,  1, 5'b10111, 0, 0, 0,  0);
        vecs[17] = mk(0, 0, 0,  0,  1, 5'b00111, 1, 3, 9,  0); // rr=1 -> u3 first
        vecs[18] = mk(0, 0, 0,  0,  1, 5'b01111, 1, 4, 10, 0);
        vecs[19] = mk(0, 0, 0,  0,  1, 5'b11111, 0, 0, 0,  0);

        bus.issue_valid   = 1'b0;
        bus.issue_unit    = '0;
        bus.issue_latency = '0;
        bus.issue_id      = '0;
        bus.wb_ready      = 1'b1;
        reset             = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            cyc($sformatf("vec%0d", i), vecs[i].iv, vecs[i].iu, vecs[i].il, vecs[i].iid,
                vecs[i].wb, vecs[i].free, vecs[i].dv, vecs[i].du, vecs[i].did, vecs[i].err);
        end

        // Three units finish together with pointer 0: grants 0, 2, 4.
        cyc("tf_rst", 0, 0, 0, 0, 1, 5'b11111, 0, 0, 0, 0, 1'b1);
        cyc("tf0",    1, 0, 3, 1, 1, 5'b11111, 0, 0, 0, 0);
        cyc("tf1",    1, 2, 2, 2, 1, 5'b11110, 0, 0, 0, 0);
        cyc("tf2",    1, 4, 1, 3, 1, 5'b11010, 0, 0, 0, 0);
        cyc("tf3",    0, 0, 0, 0, 1, 5'b01010, 1, 0, 1, 0);
        cyc("tf4",    0, 0, 0, 0, 1, 5'b01011, 1, 2, 2, 0);
        cyc("tf5",    0, 0, 0, 0, 1, 5'b01111, 1, 4, 3, 0);
        // Pointer back at 0: with u1 and u4 done together, u1 wins.
        cyc("pt0",    1, 4, 2, 6, 1, 5'b11111, 0, 0, 0, 0);
        cyc("pt1",    1, 1, 1, 8, 1, 5'b01111, 0, 0, 0, 0);
        cyc("pt2",    0, 0, 0, 0, 1, 5'b01101, 1, 1, 8, 0);
        cyc("pt3",    0, 0, 0, 0, 1, 5'b01111, 1, 4, 6, 0);
        cyc("pt4",    0, 0, 0, 0, 0, 5'b11111, 0, 0, 0, 0);

        // Back-pressure on u3; u0 finishing meanwhile must not steal the offer.
        cyc("bp0",    1, 3, 1, 12, 0, 5'b11111, 0, 0, 0,  0);
        cyc("bp1",    1, 3, 2, 13, 0, 5'b10111, 1, 3, 12, 0);
        cyc("bp2",    1, 0, 1, 1,  0, 5'b10111, 1, 3, 12, 1);
        cyc("bp3",    0, 0, 0, 0,  0, 5'b10110, 1, 3, 12, 0);
        cyc("bp4",    0, 0, 0, 0,  1, 5'b10110, 1, 3, 12, 0);
        cyc("bp5",    0, 0, 0, 0,  1, 5'b11110, 1, 0, 1,  0);
        cyc("bp6",    0, 0, 0, 0,  1, 5'b11111, 0, 0, 0,  0);

        // Reset with two units executing discards both ops.
        cyc("rm0",    1, 1, 5, 4, 1, 5'b11111, 0, 0, 0, 0);
        cyc("rm1",    1, 2, 6, 5, 1, 5'b11101, 0, 0, 0, 0);
        cyc("rm2",    1, 1, 2, 9, 1, 5'b11001, 0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc($sformatf("rm_after%0d", i), 0, 0, 0, 0, 1, 5'b11111, 0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
